// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package mul8_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W    = 8;
    localparam int NIB_W   = 4;
    localparam int PROD_W  = 16;
    localparam int STEP_W  = 2;
    localparam int SHIFT_W = 4;

    // Left shift applied to the partial product of each step.
    localparam logic [SHIFT_W-1:0] SHIFT0 = 4'd0;
    localparam logic [SHIFT_W-1:0] SHIFT1 = 4'd4;
    localparam logic [SHIFT_W-1:0] SHIFT2 = 4'd4;
    localparam logic [SHIFT_W-1:0] SHIFT3 = 4'd8;

    function automatic logic [SHIFT_W-1:0] step_shift(input logic [STEP_W-1:0] step);
        logic [SHIFT_W-1:0] sh;
        case (step)
            2'd0:    sh = SHIFT0;
            2'd1:    sh = SHIFT1;
            2'd2:    sh = SHIFT2;
            default: sh = SHIFT3;
        endcase
        return sh;
    endfunction

    // Step bit 0 picks the high nibble of A, step bit 1 the high nibble of B.
    function automatic logic [NIB_W-1:0] nib_a(input logic [STEP_W-1:0] step,
                                               input logic [OP_W-1:0]   a);
        return step[0] ? a[7:4] : a[3:0];
    endfunction

    function automatic logic [NIB_W-1:0] nib_b(input logic [STEP_W-1:0] step,
                                               input logic [OP_W-1:0]   b);
        return step[1] ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller around an external 4x4 multiplier.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are latched when it is accepted
// CALC  | one nibble pair issued per cycle (plus a drain cycle if REG_MUL_P)
// DONE  | one-cycle done pulse; a start here is accepted back-to-back
module mul8_seq_ctrl
    import mul8_pkg::*;
#(
    parameter int REG_MUL_P = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   data_a,
    input  logic [OP_W-1:0]   data_b,
    output logic [NIB_W-1:0]  mul_a,
    output logic [NIB_W-1:0]  mul_b,
    input  logic [OP_W-1:0]   mul_p,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t              state_q;
    state_t              state_d;
    logic [STEP_W-1:0]   step_q;
    logic                drain_q;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     b_r;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   product_q;

    // Pipeline stage used only when the multiplier product is registered.
    logic [OP_W-1:0]     p_r;
    logic [SHIFT_W-1:0]  sh_r;
    logic                v_r;

    logic                accept;
    logic                issue;
    logic                finish;
    logic [OP_W-1:0]     add_p;
    logic [SHIFT_W-1:0]  add_sh;
    logic                add_en;
    logic [PROD_W-1:0]   acc_sum;

    // Next-state decode plus the accept/issue/finish strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (REG_MUL_P != 0) begin
                    // Last CALC cycle only drains the registered step-3 product.
                    issue  = !drain_q;
                    finish = drain_q;
                end else begin
                    issue  = 1'b1;
                    finish = (step_q == 2'd3);
                end
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Nibble drive and accumulator adder; the add source is either the live or registered product.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (issue) begin
            mul_a = nib_a(step_q, a_r);
            mul_b = nib_b(step_q, b_r);
        end
        if (REG_MUL_P != 0) begin
            add_p  = p_r;
            add_sh = sh_r;
            add_en = (state_q == CALC) && v_r;
        end else begin
            add_p  = mul_p;
            add_sh = step_shift(step_q);
            add_en = (state_q == CALC);
        end
        acc_sum = acc_q + ({{(PROD_W-OP_W){1'b0}}, add_p} << add_sh);
    end

    // State, operand latches, step counter, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            drain_q   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            p_r       <= '0;
            sh_r      <= '0;
            v_r       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_r     <= data_a;
                b_r     <= data_b;
                acc_q   <= '0;
                step_q  <= '0;
                drain_q <= 1'b0;
                v_r     <= 1'b0;
            end else if (state_q == CALC) begin
                if (issue) begin
                    step_q <= step_q + 2'd1;
                    if ((REG_MUL_P != 0) && (step_q == 2'd3)) begin
                        drain_q <= 1'b1;
                    end
                end
                if (add_en) begin
                    acc_q <= acc_sum;
                end
                p_r  <= mul_p;
                sh_r <= step_shift(step_q);
                v_r  <= issue;
            end
            if (finish) begin
                product_q <= acc_sum;
            end
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl: one instance per REG_MUL_P setting, each with a 4x4 multiplier model.
module tb_mul8_seq_ctrl;

    typedef struct {
        bit          sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [3:0]  ma0, mb0, ma1, mb1;
    logic [7:0]  p0, p1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] prod0, prod1;

    assign p0 = {4'b0, ma0} * {4'b0, mb0};
    assign p1 = {4'b0, ma1} * {4'b0, mb1};

    mul8_seq_ctrl #(.REG_MUL_P(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_a(a0), .data_b(b0),
        .mul_a(ma0), .mul_b(mb0), .mul_p(p0), .busy(busy0), .done(done0), .product(prod0)
    );

    mul8_seq_ctrl #(.REG_MUL_P(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_a(a1), .data_b(b1),
        .mul_a(ma1), .mul_b(mb1), .mul_p(p1), .busy(busy1), .done(done1), .product(prod1)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] prev0 = '0;
    logic [15:0] prev1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            start1 = s; a1 = a; b1 = b;
        end else begin
            start0 = s; a0 = a; b0 = b;
        end
    endtask

    task automatic sample(input bit sel, output logic bsy, output logic dn,
                          output logic [15:0] pr, output logic [3:0] na, output logic [3:0] nb);
        bsy = sel ? busy1 : busy0;
        dn  = sel ? done1 : done0;
        pr  = sel ? prod1 : prod0;
        na  = sel ? ma1 : ma0;
        nb  = sel ? mb1 : mb0;
    endtask

    // One operation from an idle controller; checks busy/done timing, held product and nibble order.
    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int lat;
        logic bsy, dn;
        logic [15:0] pr, prev;
        logic [3:0] na, nb;
        logic [1:0] st;
        lat  = sel ? 6 : 5;
        prev = sel ? prev1 : prev0;
        @(posedge clk); #1;
        drive(sel, 1'b1, a, b);
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            drive(sel, 1'b0, 8'($urandom), 8'($urandom));
            @(negedge clk);
            sample(sel, bsy, dn, pr, na, nb);
            check($sformatf("busy r%0d %h*%h c%0d", sel, a, b, c), 32'(bsy), 32'(c < lat));
            check($sformatf("done r%0d %h*%h c%0d", sel, a, b, c), 32'(dn), 32'(c == lat));
            check($sformatf("product r%0d %h*%h c%0d", sel, a, b, c), 32'(pr), 32'((c >= lat) ? exp : prev));
            if (c <= 4) begin
                st = 2'(c - 1);
                check($sformatf("mul_a r%0d %h*%h c%0d", sel, a, b, c), 32'(na), 32'(st[0] ? a[7:4] : a[3:0]));
                check($sformatf("mul_b r%0d %h*%h c%0d", sel, a, b, c), 32'(nb), 32'(st[1] ? b[7:4] : b[3:0]));
            end
        end
        if (sel) prev1 = exp; else prev0 = exp;
    endtask

    initial begin
        vec_t vecs[8];
        int ndone;
        logic bsy, dn;
        logic [15:0] pr;
        logic [3:0] na, nb;

        vecs[0] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{1'b0, 8'h00, 8'hA5, 16'h0000};
        vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
        vecs[5] = '{1'b1, 8'hAB, 8'hCD, 16'h88EF};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
        vecs[7] = '{1'b1, 8'h0F, 8'hF0, 16'h0E10};

        // Reset state of both instances.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy0", 32'(busy0), 32'd0);
        check("reset done0", 32'(done0), 32'd0);
        check("reset product0", 32'(prod0), 32'd0);
        check("reset mul_a0", 32'(ma0), 32'd0);
        check("reset mul_b0", 32'(mb0), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset product1", 32'(prod1), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].prod);
            @(negedge clk);
            sample(vecs[i].sel, bsy, dn, pr, na, nb);
            check($sformatf("idle after vec%0d mul_a", i), 32'(na), 32'd0);
            check($sformatf("idle after vec%0d done", i), 32'(dn), 32'd0);
        end

        // Start pulsed mid-computation must be ignored.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h0F, 8'h10);
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            drive(1'b0, (c == 2), 8'h55, 8'h66);
            @(negedge clk);
            if (done0) ndone++;
            if (c == 5) check("ignore product c5", 32'(prod0), 32'h00F0);
        end
        check("ignore done count", 32'(ndone), 32'd1);
        check("ignore product end", 32'(prod0), 32'h00F0);

        // Back-to-back start in the DONE cycle.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h12, 8'h34);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 5) drive(1'b0, 1'b1, 8'h03, 8'h05);
            else        drive(1'b0, 1'b0, 8'hEE, 8'hDD);
            @(negedge clk);
            check($sformatf("b2b busy c%0d", c), 32'(busy0), 32'((c <= 4) || (c >= 6 && c <= 9)));
            check($sformatf("b2b done c%0d", c), 32'(done0), 32'(c == 5 || c == 10));
            if (c >= 5 && c <= 9) check($sformatf("b2b product c%0d", c), 32'(prod0), 32'h03A8);
            if (c >= 10)          check($sformatf("b2b product c%0d", c), 32'(prod0), 32'h000F);
        end

        // Reset in cycle 3 aborts the operation.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h80, 8'h80);
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 8'h00, 8'h00);
            rst = (c == 3);
            @(negedge clk);
            if (c == 4) begin
                check("abort busy", 32'(busy0), 32'd0);
                check("abort done", 32'(done0), 32'd0);
                check("abort product", 32'(prod0), 32'd0);
                check("abort mul_a", 32'(ma0), 32'd0);
            end
            if (c >= 5 && done0) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        prev0 = '0;
        prev1 = '0;
        run_op(1'b0, 8'h02, 8'h03, 16'h0006);
        run_op(1'b1, 8'h02, 8'h03, 16'h0006);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
